mem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the shared main memory (512 x 32, read/write).
- Accepts read/write requests from two private caches (requesters 0 and 1) in the MSI system.
- Grants one requester at a time on a round-robin basis, drives the memory control, address and data lines for a fixed access window, and returns a one-cycle ack together with the read data.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_arb2.sv | 21 ++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEF_AWIDTH = 9;
  localparam int DEF_DWIDTH = 32;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin picker
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  // A lone request wins outright; on a tie the side not served last wins
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_grant;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and sequencer for main memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH  = DEF_AWIDTH,
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [DWIDTH-1:0] wdata0,
  output logic              ack0,
  output logic [DWIDTH-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              ack1,
  output logic [DWIDTH-1:0] rdata1,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              busy,
  output logic              gnt_id
);

  // The counter only has to hold MEM_LAT-1
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_e  state, state_d;
  logic [CW-1:0] cnt;
  logic        we_q;
  logic        last_grant;
  logic        arb_valid;
  logic        arb_winner;
  logic        grant;
  logic        done;

  rr_arb2 u_rr_arb2 (
    .req        ({req1, req0}),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .winner     (arb_winner)
  );

  assign busy = (state != IDLE);

  // Next-state logic: grant from IDLE, leave ACCESS when the window expires
  always_comb begin
    state_d = state;
    grant   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_valid) begin
          grant   = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          done    = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Datapath: latch the winner, hold the strobes for the window, return ack and data
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (grant) begin
        gnt_id    <= arb_winner;
        cnt       <= CW'(MEM_LAT - 1);
        if (arb_winner == REQ1) begin
          we_q      <= we1;
          mem_rd    <= ~we1;
          mem_wr    <= we1;
          mem_addr  <= addr1;
          mem_wdata <= wdata1;
        end else begin
          we_q      <= we0;
          mem_rd    <= ~we0;
          mem_wr    <= we0;
          mem_addr  <= addr0;
          mem_wdata <= wdata0;
        end
      end
      if (state == ACCESS && !done) begin
        cnt <= cnt - 1'b1;
      end
      if (done) begin
        mem_rd <= 1'b0;
        mem_wr <= 1'b0;
        if (gnt_id == REQ0) ack0 <= 1'b1;
        else                ack1 <= 1'b1;
        if (!we_q) begin
          if (gnt_id == REQ0) rdata0 <= mem_rdata;
          else                rdata1 <= mem_rdata;
        end
      end
      if (state == RESP) begin
        last_grant <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int L1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] seed;
  logic        mem_init;

  // instance a: MEM_LAT = 1
  logic          rst_a;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, mem_rd, mem_wr, busy, gnt_id;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_a [512];

  // instance b: MEM_LAT = 3
  logic          b_rst;
  logic          b_req0, b_we0, b_req1, b_we1;
  logic [AW-1:0] b_addr0, b_addr1;
  logic [DW-1:0] b_wdata0, b_wdata1;
  logic          b_ack0, b_ack1, b_mem_rd, b_mem_wr, b_busy, b_gnt_id;
  logic [DW-1:0] b_rdata0, b_rdata1, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0] b_mem_addr;
  logic [DW-1:0] mem_b [512];

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MEM_LAT(L1)) dut_a (
    .clk(clk), .reset(rst_a),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .gnt_id(gnt_id)
  );

  mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MEM_LAT(3)) dut_b (
    .clk(clk), .reset(b_rst),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .ack1(b_ack1), .rdata1(b_rdata1),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .gnt_id(b_gnt_id)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B1) ^ seed;
  endfunction

  // Memories: combinational read, write latched on the falling edge
  assign mem_rdata   = mem_a[mem_addr];
  assign b_mem_rdata = mem_b[b_mem_addr];
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (mem_wr)   mem_a[mem_addr]   <= mem_wdata;
      if (b_mem_wr) mem_b[b_mem_addr] <= b_mem_wdata;
    end
  end

  // Reference model for instance a: a timeline of grants and expected results
  logic [31:0]   shadow [512];
  int            next_idle;
  bit            act_v;
  int            act_n;
  int            act_start;
  bit            act_we;
  logic [AW-1:0] act_addr;
  logic [DW-1:0] act_wdata, act_rexp;
  int            last_g;
  int            exp_gnt;
  logic [DW-1:0] exp_rd [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    next_idle = cyc;
    act_v     = 0;
    last_g    = 1;
    exp_gnt   = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  task automatic issue(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Decide what the arbiter does with this cycle's requests
  task automatic decide();
    int w;
    if (cyc >= next_idle && (req0 || req1)) begin
      if (req0 && req1) w = (last_g == 0) ? 1 : 0;
      else              w = req1 ? 1 : 0;
      act_v     = 1;
      act_n     = w;
      act_start = cyc + 1;
      act_we    = (w == 1) ? we1 : we0;
      act_addr  = (w == 1) ? addr1 : addr0;
      act_wdata = (w == 1) ? wdata1 : wdata0;
      if (act_we) shadow[act_addr] = act_wdata;
      else        act_rexp = shadow[act_addr];
      next_idle = cyc + L1 + 2;
      last_g    = w;
      exp_gnt   = w;
    end
  endtask

  task automatic check_a();
    bit in_acc;
    bit in_resp;
    in_acc  = act_v && cyc >= act_start && cyc < act_start + L1;
    in_resp = act_v && cyc == act_start + L1;
    chk("busy", busy, in_acc || in_resp);
    chk("mem_rd", mem_rd, in_acc && !act_we);
    chk("mem_wr", mem_wr, in_acc && act_we);
    if (in_acc) chk("mem_addr", mem_addr, act_addr);
    if (in_acc && act_we) chk("mem_wdata", mem_wdata, act_wdata);
    chk("ack0", ack0, in_resp && act_n == 0);
    chk("ack1", ack1, in_resp && act_n == 1);
    chk("gnt_id", gnt_id, exp_gnt);
    if (in_resp && !act_we) exp_rd[act_n] = act_rexp;
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    if (in_resp) begin
      if (act_n == 0) req0 = 1'b0;
      else            req1 = 1'b0;
      act_v = 0;
    end
  endtask

  task automatic tick_a();
    decide();
    @(posedge clk);
    #1;
    check_a();
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    model_reset();
    check_a();
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
  endtask

  // Ticks until requester n is acked; checks the latency, then one idle tick
  task automatic wait_ack_a(input int n, input int exp_ticks, input string tag);
    int t;
    bit got;
    t = 0;
    got = 0;
    while (!got && t < 20) begin
      tick_a();
      t++;
      if ((n == 0) ? ack0 : ack1) got = 1;
    end
    chk({tag, "_lat"}, t, exp_ticks);
    tick_a();
  endtask

  task automatic drain_a();
    int t;
    t = 0;
    while ((req0 || req1) && t < 40) begin
      tick_a();
      t++;
    end
    chk("drain", req0 | req1, 0);
    tick_a();
  endtask

  task automatic tick_b();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    int t0;
    int t1;
    int nseq;
    logic [3:0] order;
    logic [31:0] exp_b;

    seed = $urandom;
    mem_init = 1'b1;
    rst_a = 1'b1; b_rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    b_req0 = 0; b_we0 = 0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 0; b_we1 = 0; b_addr1 = '0; b_wdata1 = '0;
    for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
    @(negedge clk);
    #1;
    mem_init = 1'b0;

    // Write then read by requester 0, then isolation of rdata0
    reset_a();
    issue(0, 1'b1, 9'h005, 32'hDEADBEEF);
    wait_ack_a(0, 2, "wr0");
    chk("mem_5", mem_a[5], 32'hDEADBEEF);
    issue(0, 1'b0, 9'h005, 32'h0);
    wait_ack_a(0, 2, "rd0");
    chk("rd0_data", rdata0, 32'hDEADBEEF);
    issue(1, 1'b0, 9'h1A0, 32'h0);
    wait_ack_a(1, 2, "rd1");
    chk("iso_rd1", rdata0, 32'hDEADBEEF);
    issue(0, 1'b1, 9'h0AB, $urandom);
    wait_ack_a(0, 2, "wr0b");
    chk("iso_wr0", rdata0, 32'hDEADBEEF);

    // Contention from reset: 0 first, then strict alternation
    reset_a();
    issue(0, 1'b0, 9'h010, 32'h0);
    issue(1, 1'b0, 9'h020, 32'h0);
    t = 0; t0 = -1; t1 = -1; nseq = 0; order = 4'h0;
    while (nseq < 4 && t < 40) begin
      tick_a();
      t++;
      if (ack0) begin
        if (t0 < 0) t0 = t;
        order[nseq] = 1'b0;
        nseq++;
        if (nseq < 4) issue(0, 1'b0, 9'h010, 32'h0);
      end
      if (ack1 && nseq < 4) begin
        if (t1 < 0) t1 = t;
        order[nseq] = 1'b1;
        nseq++;
        if (nseq < 4) issue(1, 1'b0, 9'h020, 32'h0);
      end
    end
    chk("cont_ack0_lat", t0, 2);
    chk("cont_ack1_lat", t1, 5);
    chk("cont_count", nseq, 4);
    chk("cont_order", order, 4'b1010);
    drain_a();

    // Fairness after reset: lone req1 served, then a tie goes to requester 0
    reset_a();
    issue(1, 1'b0, 9'h030, 32'h0);
    wait_ack_a(1, 2, "fair1");
    issue(0, 1'b0, 9'h031, 32'h0);
    issue(1, 1'b0, 9'h032, 32'h0);
    t = 0;
    while (!(ack0 || ack1) && t < 20) begin
      tick_a();
      t++;
    end
    chk("fair_first_ack0", ack0, 1);
    chk("fair_first_ack1", ack1, 0);
    drain_a();

    // Randomized traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      if (!req0 && $urandom_range(0, 2) == 0)
        issue(0, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom);
      if (!req1 && $urandom_range(0, 2) == 0)
        issue(1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), $urandom);
      tick_a();
    end
    drain_a();

    // MEM_LAT = 3: read of the top address
    repeat (2) @(posedge clk);
    #1;
    b_rst = 1'b0;
    exp_b = init_word(511);
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 9'h1FF;
    for (int k = 1; k <= 6; k++) begin
      tick_b();
      chk("b_mem_rd", b_mem_rd, (k >= 1 && k <= 3));
      chk("b_mem_wr", b_mem_wr, 0);
      chk("b_ack0", b_ack0, (k == 4));
      chk("b_ack1", b_ack1, 0);
      if (k <= 3) chk("b_mem_addr", b_mem_addr, 9'h1FF);
      if (k == 4) begin
        chk("b_rdata0", b_rdata0, exp_b);
        b_req0 = 1'b0;
      end
    end

    // MEM_LAT = 3: reset in the second cycle of a write
    b_req0 = 1'b1; b_we0 = 1'b1; b_addr0 = 9'h040; b_wdata0 = $urandom;
    tick_b();
    chk("b_wr_c1", b_mem_wr, 1);
    tick_b();
    chk("b_wr_c2", b_mem_wr, 1);
    b_rst = 1'b1;
    b_req0 = 1'b0;
    tick_b();
    chk("b_rst_mem_wr", b_mem_wr, 0);
    chk("b_rst_mem_rd", b_mem_rd, 0);
    chk("b_rst_busy", b_busy, 0);
    chk("b_rst_ack0", b_ack0, 0);
    chk("b_rst_ack1", b_ack1, 0);
    chk("b_rst_gnt", b_gnt_id, 0);
    chk("b_rst_addr", b_mem_addr, 0);
    chk("b_rst_wdata", b_mem_wdata, 0);
    chk("b_rst_rdata0", b_rdata0, 0);
    chk("b_rst_rdata1", b_rdata1, 0);
    b_rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick_b();
      chk("b_post_ack0", b_ack0, 0);
      chk("b_post_busy", b_busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
